// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types for the load/store unit: access size encoding, FSM state
// encoding and the alignment rule used when LSU_ALIGN_CHECK_EN is defined.
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B    = 2'd0,
        SIZE_H    = 2'd1,
        SIZE_W    = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        ACCESS_HI = 2'd2,
        DONE      = 2'd3
    } state_e;

    // Half needs an even address, word a multiple of four; the reserved size
    // is never a legal access.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lsb);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_H:    bad = addr_lsb[0];
            SIZE_W:    bad = (addr_lsb != 2'b00);
            SIZE_RSVD: bad = 1'b1;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational sign/zero extension of raw little-endian load data.
//   data        in  32  raw word read at the access address
//   size        in  2   access size (reserved size behaves as word)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   ext         out 32  extended result
// -----------------------------------------------------------------------------
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);

    always_comb begin
        // NOTE: default assignment first so every path drives ext -- no latch.
        ext = data;
        case (size)
            SIZE_B:  ext = {{24{~is_unsigned & data[7]}},  data[7:0]};
            SIZE_H:  ext = {{16{~is_unsigned & data[15]}}, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the byte/word RAM port. Accepts one load/store request at a
// time over valid/ready, runs the RAM cycle(s) and returns one response pulse.
// Half stores are issued as two byte writes (low byte, then address + 1).
//
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned requests
// (half at odd address, word not on a 4-byte boundary, reserved size) with
// resp_err=1 and no RAM cycle. Without it resp_err is tied 0 and the reserved
// size behaves as word.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_write, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err                         response
//   write_enable, is32bitWrite, addr, bus_to_mem, bus_to_mem_32  to RAM
//   bus_from_mem, bus_from_mem_32                                from RAM
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              write_enable,
    output logic              is32bitWrite,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        bus_to_mem,
    output logic [31:0]       bus_to_mem_32,
    input  logic [7:0]        bus_from_mem,
    input  logic [31:0]       bus_from_mem_32
);

    state_e      state;
    logic        we_q;
    size_e       req_size_e;
    logic        handshake;
    logic        reject;

    // Request payload held for the duration of the access.
    size_e       lat_size;
    logic        lat_write;
    logic        lat_unsigned;
    logic [7:0]  hi_byte;

    logic [31:0] load_data;
    logic [31:0] load_ext;

    assign req_size_e = size_e'(req_size);
    assign req_ready  = (state == IDLE) && !rst;
    assign handshake  = req_valid && req_ready;

    // Gated by rst so a reset landing in ACCESS_HI suppresses the high-byte
    // write at that same edge instead of letting the RAM commit it.
    assign write_enable = we_q && !rst;

`ifdef LSU_ALIGN_CHECK_EN
    logic err_q;

    assign reject   = is_misaligned(req_size_e, req_addr[1:0]);
    assign resp_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (handshake) begin
            err_q <= reject;
        end
    end
`else
    assign reject   = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Byte loads take the low lane from the dedicated byte read port; both
    // ports present the same RAM byte at addr.
    assign load_data = (lat_size == SIZE_B) ? {bus_from_mem_32[31:8], bus_from_mem}
                                            : bus_from_mem_32;

    load_extend u_load_extend (
        .data        (load_data),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .ext         (load_ext)
    );

    // NOTE: payload registers are only read after a handshake loads them, so
    // they carry no reset.
    always_ff @(posedge clk) begin
        if (handshake) begin
            lat_size     <= req_size_e;
            lat_write    <= req_write;
            lat_unsigned <= req_unsigned;
            hi_byte      <= req_wdata[15:8];
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            we_q          <= 1'b0;
            is32bitWrite  <= 1'b0;
            addr          <= '0;
            bus_to_mem    <= '0;
            bus_to_mem_32 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        if (reject) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state        <= ACCESS;
                            addr         <= req_addr;
                            we_q         <= req_write;
                            is32bitWrite <= req_write &&
                                            (req_size_e == SIZE_W || req_size_e == SIZE_RSVD);
                            if (req_write) begin
                                bus_to_mem    <= req_wdata[7:0];
                                bus_to_mem_32 <= req_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (lat_write && lat_size == SIZE_H) begin
                        state      <= ACCESS_HI;
                        addr       <= addr + ADDR_W'(1);
                        bus_to_mem <= hi_byte;
                    end else begin
                        state        <= DONE;
                        we_q         <= 1'b0;
                        is32bitWrite <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_rdata   <= lat_write ? 32'd0 : load_ext;
                    end
                end
                ACCESS_HI: begin
                    state      <= DONE;
                    we_q       <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: a 256-byte RAM responder, a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run against a byte-array
// reference model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        write_enable;
    logic        is32bitWrite;
    logic [31:0] addr;
    logic [7:0]  bus_to_mem;
    logic [31:0] bus_to_mem_32;
    logic [7:0]  bus_from_mem;
    logic [31:0] bus_from_mem_32;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .write_enable    (write_enable),
        .is32bitWrite    (is32bitWrite),
        .addr            (addr),
        .bus_to_mem      (bus_to_mem),
        .bus_to_mem_32   (bus_to_mem_32),
        .bus_from_mem    (bus_from_mem),
        .bus_from_mem_32 (bus_from_mem_32)
    );

    // ---------------- RAM responder (address taken modulo 256) ----------------
    logic [7:0] mem [256];

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        w32;
    } wr_t;
    wr_t wlog[$];

    assign bus_from_mem    = mem[addr[7:0]];
    assign bus_from_mem_32 = {mem[8'(addr[7:0] + 8'd3)], mem[8'(addr[7:0] + 8'd2)],
                              mem[8'(addr[7:0] + 8'd1)], mem[addr[7:0]]};

    always @(posedge clk) begin
        if (write_enable) begin
            if (is32bitWrite) begin
                for (int k = 0; k < 4; k++)
                    mem[8'(addr[7:0] + 8'(k))] <= bus_to_mem_32[8*k +: 8];
            end else begin
                mem[addr[7:0]] <= bus_to_mem;
            end
            wlog.push_back('{addr, is32bitWrite ? bus_to_mem_32 : {24'd0, bus_to_mem}, is32bitWrite});
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256];

    function automatic void ref_exec(input logic w, input logic [1:0] sz, input logic un,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er,
                                     output int lat, output int nwr);
        int     nbytes;
        longint v;
        logic   bad;
        bad = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        bad = (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0) || (sz == 2'd3);
`endif
        if (bad) begin
            rd = 32'd0; er = 1'b1; lat = 1; nwr = 0;
            return;
        end
        er = 1'b0;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (w) begin
            for (int i = 0; i < nbytes; i++)
                ref_mem[(a + 32'(i)) % 256] = wd[8*i +: 8];
            rd  = 32'd0;
            lat = (sz == 2'd1) ? 3 : 2;
            nwr = (sz == 2'd1) ? 2 : 1;
        end else begin
            v = 0;
            for (int i = 0; i < nbytes; i++)
                v = v + (longint'(ref_mem[(a + 32'(i)) % 256]) << (8 * i));
            if (!un && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
                v = v - (longint'(1) << (8 * nbytes));
            rd  = 32'(v);
            lat = 2;
            nwr = 0;
        end
    endfunction

    // ---------------- one request through the handshake ----------------
    logic ready_leak;   // req_ready seen high while busy
    logic extra_pulse;  // resp_valid still high the cycle after the response

    task automatic do_req(input logic w, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int nwr);
        int waitc;
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("handshake_ready", {31'd0, req_ready}, 32'd1);
        wlog.delete();
        ready_leak = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        if (req_ready) ready_leak = 1'b1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            if (req_ready) ready_leak = 1'b1;
        end
        if (!resp_valid) lat = -1;
        rd  = resp_rdata;
        er  = resp_err;
        nwr = wlog.size();
        @(negedge clk);
        extra_pulse = resp_valid;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nwr;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat, nwr, exp_lat, exp_nwr;
        logic        w, un;
        logic [1:0]  sz;
        logic [31:0] a, wd;
        logic        seen;
        int          bad_bytes;

        for (int i = 0; i < 256; i++) mem[i] = 8'd0;

        // ---- reset: outputs at reset values, request during reset ignored ----
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h40;
        req_wdata = 32'hdeadbeef;
        repeat (3) @(negedge clk);
        check("rst req_ready",     {31'd0, req_ready},    32'd0);
        check("rst resp_valid",    {31'd0, resp_valid},   32'd0);
        check("rst resp_rdata",    resp_rdata,            32'd0);
        check("rst resp_err",      {31'd0, resp_err},     32'd0);
        check("rst write_enable",  {31'd0, write_enable}, 32'd0);
        check("rst is32bitWrite",  {31'd0, is32bitWrite}, 32'd0);
        check("rst addr",          addr,                  32'd0);
        check("rst bus_to_mem",    {24'd0, bus_to_mem},   32'd0);
        check("rst bus_to_mem_32", bus_to_mem_32,         32'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst no_write",  wlog.size(),          32'd0);
        check("post_rst mem40",     {24'd0, mem[8'h40]},  32'd0);
        check("post_rst req_ready", {31'd0, req_ready},   32'd1);

        // ---- table ----
        vecs.push_back('{"st_w_58",  1'b1, 2'd2, 1'b0, 32'h58, 32'haabbccdd, 32'h0,        1'b0, 2, 1});
        vecs.push_back('{"ld_w_58",  1'b0, 2'd2, 1'b0, 32'h58, 32'h0,        32'haabbccdd, 1'b0, 2, 0});
        vecs.push_back('{"ld_bs_59", 1'b0, 2'd0, 1'b0, 32'h59, 32'h0,        32'hffffffcc, 1'b0, 2, 0});
        vecs.push_back('{"ld_bu_59", 1'b0, 2'd0, 1'b1, 32'h59, 32'h0,        32'h000000cc, 1'b0, 2, 0});
`ifdef LSU_ALIGN_CHECK_EN
        vecs.push_back('{"ld_hu_59", 1'b0, 2'd1, 1'b1, 32'h59, 32'h0,        32'h0,        1'b1, 1, 0});
`else
        vecs.push_back('{"ld_hu_59", 1'b0, 2'd1, 1'b1, 32'h59, 32'h0,        32'h0000bbcc, 1'b0, 2, 0});
`endif
        vecs.push_back('{"ld_hs_5a", 1'b0, 2'd1, 1'b0, 32'h5a, 32'h0,        32'hffffaabb, 1'b0, 2, 0});
`ifdef LSU_ALIGN_CHECK_EN
        vecs.push_back('{"ld_w_59",  1'b0, 2'd2, 1'b0, 32'h59, 32'h0,        32'h0,        1'b1, 1, 0});
        vecs.push_back('{"ld_r_58",  1'b0, 2'd3, 1'b0, 32'h58, 32'h0,        32'h0,        1'b1, 1, 0});
        vecs.push_back('{"st_w_62",  1'b1, 2'd2, 1'b0, 32'h62, 32'h01020304, 32'h0,        1'b1, 1, 0});
`else
        vecs.push_back('{"ld_w_59",  1'b0, 2'd2, 1'b0, 32'h59, 32'h0,        32'h00aabbcc, 1'b0, 2, 0});
        vecs.push_back('{"ld_r_58",  1'b0, 2'd3, 1'b0, 32'h58, 32'h0,        32'haabbccdd, 1'b0, 2, 0});
        vecs.push_back('{"st_w_62",  1'b1, 2'd2, 1'b0, 32'h62, 32'h01020304, 32'h0,        1'b0, 2, 1});
`endif
        vecs.push_back('{"st_b_60",  1'b1, 2'd0, 1'b0, 32'h60, 32'h00000077, 32'h0,        1'b0, 2, 1});
        vecs.push_back('{"ld_bs_60", 1'b0, 2'd0, 1'b0, 32'h60, 32'h0,        32'h00000077, 1'b0, 2, 0});

        foreach (vecs[i]) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].un, vecs[i].a, vecs[i].wd, rd, er, lat, nwr);
            check({vecs[i].name, " rdata"},   rd,                    vecs[i].exp_rd);
            check({vecs[i].name, " err"},     {31'd0, er},           {31'd0, vecs[i].exp_err});
            check({vecs[i].name, " latency"}, 32'(lat),              32'(vecs[i].exp_lat));
            check({vecs[i].name, " writes"},  32'(nwr),              32'(vecs[i].exp_nwr));
            check({vecs[i].name, " busy_ready"}, {31'd0, ready_leak},  32'd0);
            check({vecs[i].name, " one_pulse"},  {31'd0, extra_pulse}, 32'd0);
        end

        // ---- half store at 0x10: two byte writes, upper bytes untouched ----
        @(negedge clk);
        mem[8'h12] = 8'h56;
        mem[8'h13] = 8'h78;
        do_req(1'b1, 2'd1, 1'b0, 32'h10, 32'h00001234, rd, er, lat, nwr);
        check("st_h_10 latency", 32'(lat), 32'd3);
        check("st_h_10 writes",  32'(nwr), 32'd2);
        if (nwr >= 2) begin
            check("st_h_10 wr0 addr", wlog[0].a, 32'h10);
            check("st_h_10 wr0 data", wlog[0].d, 32'h34);
            check("st_h_10 wr1 addr", wlog[1].a, 32'h11);
            check("st_h_10 wr1 data", wlog[1].d, 32'h12);
            check("st_h_10 wr1 w32",  {31'd0, wlog[1].w32}, 32'd0);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nwr);
        check("ld_w_10 rdata", rd, 32'h78561234);

        // ---- half store at the top of the address space ----
        do_req(1'b1, 2'd1, 1'b0, 32'hffffffff, 32'h0000a5c3, rd, er, lat, nwr);
`ifdef LSU_ALIGN_CHECK_EN
        check("st_h_wrap err",    {31'd0, er}, 32'd1);
        check("st_h_wrap writes", 32'(nwr),    32'd0);
        check("st_h_wrap latency", 32'(lat),   32'd1);
`else
        check("st_h_wrap err",    {31'd0, er}, 32'd0);
        check("st_h_wrap writes", 32'(nwr),    32'd2);
        if (nwr >= 2) begin
            check("st_h_wrap wr0 addr", wlog[0].a, 32'hffffffff);
            check("st_h_wrap wr1 addr", wlog[1].a, 32'h00000000);
            check("st_h_wrap wr1 data", wlog[1].d, 32'h000000a5);
        end
`endif

        // ---- reset during ACCESS_HI of a half store ----
        @(negedge clk);
        mem[8'h20] = 8'h11;
        mem[8'h21] = 8'h22;
        req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0000beef; req_valid = 1'b1;
        check("rsthi idle_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("rsthi access we",   {31'd0, write_enable}, 32'd1);
        check("rsthi access addr", addr, 32'h20);
        @(negedge clk);
        check("rsthi hi addr", addr, 32'h21);
        check("rsthi hi data", {24'd0, bus_to_mem}, 32'hbe);
        rst = 1'b1;
        #1;
        check("rsthi we_in_reset", {31'd0, write_enable}, 32'd0);
        @(negedge clk);
        check("rsthi we_after", {31'd0, write_enable}, 32'd0);
        check("rsthi no_resp",  {31'd0, resp_valid},   32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("rsthi no_late_resp", {31'd0, seen}, 32'd0);
        check("rsthi low_byte",  {24'd0, mem[8'h20]}, 32'hef);
        check("rsthi high_byte", {24'd0, mem[8'h21]}, 32'h22);
        do_req(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, rd, er, lat, nwr);
        check("rsthi next rdata",   rd,        32'h000022ef);
        check("rsthi next latency", 32'(lat),  32'd2);

        // ---- randomized run against the reference model ----
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom;
            ref_exec(w, sz, un, a, wd, exp_rd, exp_er, exp_lat, exp_nwr);
            do_req(w, sz, un, a, wd, rd, er, lat, nwr);
            check($sformatf("rnd%0d rdata", n),   rd,          exp_rd);
            check($sformatf("rnd%0d err", n),     {31'd0, er}, {31'd0, exp_er});
            check($sformatf("rnd%0d latency", n), 32'(lat),    32'(exp_lat));
            check($sformatf("rnd%0d writes", n),  32'(nwr),    32'(exp_nwr));
        end
        @(negedge clk);
        bad_bytes = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) bad_bytes++;
        check("rnd memory_image bad_bytes", 32'(bad_bytes), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
